// File: rtl/board_move_arbiter.sv
// board_move_arbiter: clears the column units, then drains their move FIFOs
// round-robin into a single valid/ready move stream and reports pass completion.
module board_move_arbiter #(
  parameter int NCOL    = 8,
  parameter int MOVE_W  = 160,
  parameter int CLR_CYC = 2,
  parameter int CNT_W   = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [NCOL-1:0]          col_done,
  input  logic [NCOL-1:0]          col_empty,
  input  logic [NCOL*MOVE_W-1:0]   col_data,
  output logic [NCOL-1:0]          col_rden,
  output logic                     col_reset,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [MOVE_W-1:0]        out_data,
  output logic [$clog2(NCOL)-1:0]  out_col,
  output logic [CNT_W-1:0]         move_count,
  output logic                     busy,
  output logic                     done
);
  localparam int SW = $clog2(NCOL);
  localparam int CW = $clog2(CLR_CYC + 1);
  typedef enum logic [2:0] {IDLE, CLR, SCAN, RD, LAT, PUSH, FIN} state_t;
  state_t            state_q, state_d;
  logic [CW-1:0]     clr_cnt_q, clr_cnt_d;
  logic              settle_q, settle_d;
  logic [SW-1:0]     sel_q, sel_d, rr_q, rr_d, cand, gnt_idx;
  logic              gnt_any;
  logic [NCOL-1:0]   col_rden_q, col_rden_d;
  logic              col_reset_q, col_reset_d, out_valid_q, out_valid_d;
  logic [MOVE_W-1:0] out_data_q, out_data_d;
  logic [SW-1:0]     out_col_q, out_col_d;
  logic [CNT_W-1:0]  move_count_q, move_count_d;
  logic              busy_q, busy_d, done_q, done_d;
  // first non-empty column at or after rr_q; the loop runs backwards so the nearest wins
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand = '0;
    for (int k = NCOL - 1; k >= 0; k--) begin
      cand = SW'((int'(rr_q) + k) % NCOL);
      if (!col_empty[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    clr_cnt_d = clr_cnt_q;
    settle_d = settle_q;
    sel_d = sel_q;
    rr_d = rr_q;
    col_rden_d = '0;
    col_reset_d = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d = out_data_q;
    out_col_d = out_col_q;
    move_count_d = move_count_q;
    case (state_q)
      IDLE, FIN: if (start) begin
        state_d = CLR;
        clr_cnt_d = '0;
        move_count_d = '0;
        col_reset_d = 1'b1;
      end
      CLR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        col_reset_d = clr_cnt_q != CW'(CLR_CYC - 1);
        if (clr_cnt_q == CW'(CLR_CYC - 1)) begin
          state_d = SCAN;
          settle_d = 1'b1;
        end
      end
      // the cycle right after CLR lets column flags settle before they are trusted
      SCAN: if (settle_q) settle_d = 1'b0;
        else if (gnt_any) begin
          sel_d = gnt_idx;
          col_rden_d = NCOL'(1) << gnt_idx;
          state_d = RD;
        end else if (&col_done && &col_empty) state_d = FIN;
      RD: state_d = LAT;
      LAT: begin
        out_data_d = col_data[sel_q*MOVE_W +: MOVE_W];
        out_col_d = sel_q;
        out_valid_d = 1'b1;
        state_d = PUSH;
      end
      PUSH: if (out_ready) begin
        out_valid_d = 1'b0;
        move_count_d = &move_count_q ? move_count_q : move_count_q + 1'b1;
        rr_d = SW'((int'(sel_q) + 1) % NCOL);
        state_d = SCAN;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d inside {CLR, SCAN, RD, LAT, PUSH};
    done_d = state_d == FIN;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      clr_cnt_q <= '0;
      settle_q <= 1'b0;
      sel_q <= '0;
      rr_q <= '0;
      col_rden_q <= '0;
      col_reset_q <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_col_q <= '0;
      move_count_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_cnt_q <= clr_cnt_d;
      settle_q <= settle_d;
      sel_q <= sel_d;
      rr_q <= rr_d;
      col_rden_q <= col_rden_d;
      col_reset_q <= col_reset_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_col_q <= out_col_d;
      move_count_q <= move_count_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign col_rden = col_rden_q;
  assign col_reset = col_reset_q;
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_col = out_col_q;
  assign move_count = move_count_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_board_move_arbiter.sv
// tb_board_move_arbiter: directed scenarios against a counter-based model of the column FIFOs.
module tb_board_move_arbiter;
  localparam int NCOL = 8;
  localparam int MOVE_W = 160;
  localparam int CNT_W = 10;
  logic clk = 1'b0;
  logic reset, start, out_ready;
  logic [NCOL-1:0] col_done, col_empty, col_rden;
  logic [NCOL*MOVE_W-1:0] col_data;
  logic col_reset, out_valid, busy, done;
  logic [MOVE_W-1:0] out_data;
  logic [2:0] out_col;
  logic [CNT_W-1:0] move_count;
  int total = 0, bad = 0;
  int wcnt [NCOL];
  int rcnt [NCOL];
  logic [MOVE_W-1:0] base [NCOL];

  board_move_arbiter dut (
    .clk(clk), .reset(reset), .start(start), .col_done(col_done), .col_empty(col_empty),
    .col_data(col_data), .col_rden(col_rden), .col_reset(col_reset), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_col(out_col), .move_count(move_count),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // non-show-ahead FIFOs: entry n of column c is base[c]^n, visible the cycle after rden
  always_comb begin
    col_empty = '0;
    for (int c = 0; c < NCOL; c++) col_empty[c] = wcnt[c] == rcnt[c];
  end
  always @(posedge clk)
    for (int c = 0; c < NCOL; c++)
      if (col_rden[c]) begin
        col_data[c*MOVE_W +: MOVE_W] <= base[c] ^ MOVE_W'(rcnt[c]);
        rcnt[c] <= rcnt[c] + 1;
      end

  task automatic load(input int c, input int n);
    wcnt[c] += n;
  endtask

  task automatic pulse_start;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_beat(output bit ok, output logic [2:0] col, output logic [MOVE_W-1:0] data);
    ok = 1'b0; col = '0; data = '0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin ok = 1'b1; col = out_col; data = out_data; end
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = done;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; out_ready = 1'b0; col_done = '0;
    repeat (3) @(negedge clk);
    total++; if (col_rden !== 8'h00) begin bad++; $display("FAIL rst_rden: got %0h want 0", col_rden); end
    total++; if (col_reset !== 1'b1) begin bad++; $display("FAIL rst_col_reset: got %0b want 1", col_reset); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %0b want 0", out_valid); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL rst_data: got %0h want 0", out_data); end
    total++; if (out_col !== 3'd0) begin bad++; $display("FAIL rst_col: got %0d want 0", out_col); end
    total++; if (move_count !== '0) begin bad++; $display("FAIL rst_count: got %0d want 0", move_count); end
    total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL rst_busy_done: got %b want 00", {busy, done}); end
    reset = 1'b0;
    @(negedge clk);
    total++; if (col_reset !== 1'b0) begin bad++; $display("FAIL idle_col_reset: got %0b want 0", col_reset); end
  endtask

  task automatic test_round_robin;
    int nxt [NCOL];
    logic [2:0] ec [4];
    bit ok;
    logic [2:0] col;
    logic [MOVE_W-1:0] data, exp_d;
    ec = '{3'd0, 3'd5, 3'd0, 3'd5};
    for (int c = 0; c < NCOL; c++) nxt[c] = wcnt[c];
    col_done = 8'hFF; out_ready = 1'b1;
    load(0, 2); load(5, 2);
    pulse_start;
    for (int b = 0; b < 4; b++) begin
      wait_beat(ok, col, data);
      exp_d = base[ec[b]] ^ MOVE_W'(nxt[ec[b]]);
      nxt[ec[b]]++;
      total++; if (!ok || col !== ec[b]) begin bad++; $display("FAIL rr_col%0d: got %0d (ok=%0b) want %0d", b, col, ok, ec[b]); end
      total++; if (data !== exp_d) begin bad++; $display("FAIL rr_data%0d: got %0h want %0h", b, data, exp_d); end
    end
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rr_done_early: got %0b want 0", done); end
    @(negedge clk);
    total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL rr_done: got done=%0b busy=%0b want 1 0", done, busy); end
    total++; if (move_count !== 10'd4) begin bad++; $display("FAIL rr_count: got %0d want 4", move_count); end
  endtask

  task automatic test_empty_pass;
    int cr = 0, rd = 0;
    col_done = 8'hFF;
    @(negedge clk) start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk) start = 1'b0;
      if (col_reset) cr++;
      if (|col_rden) rd++;
      if (done) break;
    end
    total++; if (cr != 2) begin bad++; $display("FAIL empty_clr_cycles: got %0d want 2", cr); end
    total++; if (rd != 0) begin bad++; $display("FAIL empty_rden: got %0d want 0", rd); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL empty_done: got %0b want 1", done); end
    total++; if (move_count !== '0) begin bad++; $display("FAIL empty_count: got %0d want 0", move_count); end
  endtask

  task automatic test_backpressure;
    logic [MOVE_W-1:0] pat;
    int rd3 = 0, rdo = 0;
    bit ok;
    pat = {20{8'hA5}};
    col_done = 8'hFF; out_ready = 1'b0;
    base[3] = pat ^ MOVE_W'(wcnt[3]);
    load(3, 1);
    @(negedge clk) start = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk) start = 1'b0;
      rd3 += int'(col_rden[3]);
      rdo += int'(|(col_rden & 8'hF7));
      if (out_valid) break;
    end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid: got %0b want 1", out_valid); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rd3 += int'(col_rden[3]);
      rdo += int'(|col_rden);
      total++;
      if (out_valid !== 1'b1 || out_data !== pat || out_col !== 3'd3 || move_count !== '0) begin
        bad++; $display("FAIL bp_hold%0d: got v=%0b d=%0h c=%0d n=%0d want 1 %0h 3 0", i, out_valid, out_data, out_col, move_count, pat);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    total++; if (out_valid !== 1'b0 || move_count !== 10'd1) begin bad++; $display("FAIL bp_accept: got v=%0b n=%0d want 0 1", out_valid, move_count); end
    total++; if (rd3 != 1 || rdo != 0) begin bad++; $display("FAIL bp_rden: got col3=%0d other=%0d want 1 0", rd3, rdo); end
    wait_done(ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_fin: got done=%0b want 1", done); end
  endtask

  task automatic test_wrap;
    bit ok;
    logic [2:0] col;
    logic [MOVE_W-1:0] data;
    col_done = 8'h00; out_ready = 1'b1;
    load(6, 1);
    pulse_start;
    wait_beat(ok, col, data);
    total++; if (!ok || col !== 3'd6) begin bad++; $display("FAIL wrap_first: got %0d (ok=%0b) want 6", col, ok); end
    @(negedge clk);
    load(7, 1); load(1, 1);
    wait_beat(ok, col, data);
    total++; if (!ok || col !== 3'd7) begin bad++; $display("FAIL wrap_7: got %0d (ok=%0b) want 7", col, ok); end
    wait_beat(ok, col, data);
    total++; if (!ok || col !== 3'd1) begin bad++; $display("FAIL wrap_1: got %0d (ok=%0b) want 1", col, ok); end
    col_done = 8'hFF;
    wait_done(ok);
    total++; if (!ok) begin bad++; $display("FAIL wrap_fin: got done=%0b want 1", done); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    logic [2:0] col;
    logic [MOVE_W-1:0] data;
    col_done = 8'h00; out_ready = 1'b1;
    load(2, 1); load(4, 1);
    pulse_start;
    wait_beat(ok, col, data);
    @(negedge clk) out_ready = 1'b0;
    for (int i = 0; i < 50 && !out_valid; i++) @(negedge clk);
    total++; if (out_valid !== 1'b1 || move_count !== 10'd1 || out_col !== 3'd4) begin
      bad++; $display("FAIL mid_push: got v=%0b n=%0d c=%0d want 1 1 4", out_valid, move_count, out_col);
    end
    reset = 1'b1;
    @(negedge clk);
    total++; if (out_valid !== 1'b0 || move_count !== '0) begin bad++; $display("FAIL mid_abort: got v=%0b n=%0d want 0 0", out_valid, move_count); end
    total++; if (col_reset !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || col_rden !== '0) begin
      bad++; $display("FAIL mid_idle: got cr=%0b busy=%0b done=%0b rden=%0h want 1 0 0 0", col_reset, busy, done, col_rden);
    end
    reset = 1'b0;
    @(negedge clk);
    total++; if (col_reset !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mid_release: got cr=%0b busy=%0b want 0 0", col_reset, busy); end
  endtask

  task automatic test_saturate;
    int nxt [NCOL];
    int beats = 0, cr = 0, viol = 0, derr = 0;
    logic [2:0] ecol;
    for (int c = 0; c < NCOL; c++) nxt[c] = wcnt[c];
    col_done = 8'hFF; out_ready = 1'b1;
    load(0, 600); load(3, 500);
    pulse_start;
    for (int i = 0; i < 10 && col_reset; i++) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (col_reset) cr++;
      if (|col_rden && out_valid) viol++;
      if (out_valid && out_ready) begin
        ecol = beats < 1000 ? ((beats % 2) != 0 ? 3'd3 : 3'd0) : 3'd0;
        if (out_col !== ecol || out_data !== (base[ecol] ^ MOVE_W'(nxt[ecol]))) derr++;
        nxt[ecol]++;
        beats++;
      end
      if (done) break;
    end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL sat_done: got %0b want 1", done); end
    total++; if (beats != 1100) begin bad++; $display("FAIL sat_beats: got %0d want 1100", beats); end
    total++; if (move_count !== 10'd1023) begin bad++; $display("FAIL sat_count: got %0d want 1023", move_count); end
    total++; if (cr != 0) begin bad++; $display("FAIL sat_restart: got col_reset cycles %0d want 0", cr); end
    total++; if (viol != 0) begin bad++; $display("FAIL sat_rden_valid: got %0d overlaps want 0", viol); end
    total++; if (derr != 0) begin bad++; $display("FAIL sat_order_data: got %0d bad beats want 0", derr); end
  endtask

  initial begin
    for (int c = 0; c < NCOL; c++) base[c] = {5{32'h9E37_79B9 + 32'(c * 32'h0101_0101)}};
    reset = 1'b1; start = 1'b0; out_ready = 1'b0; col_done = '0;
    test_reset;
    test_round_robin;
    test_empty_pass;
    test_backpressure;
    test_wrap;
    test_reset_mid;
    test_saturate;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/board_move_arbiter.md
Name: board_move_arbiter

Overview:
Board-level scheduler for the eight column units of the move generator. On a start pulse it clears the columns and then drains their per-column move FIFOs round-robin into one 160-bit output stream with a valid/ready handshake. It signals done once every column has finished and every FIFO is empty. It sits between the eight column units and the downstream move consumer (search/evaluation logic).

Parameters:
NCOL, 8, number of column units (one FIFO per column)
MOVE_W, 160, width of one column FIFO entry
CLR_CYC, 2, cycles col_reset is held high after start
CNT_W, 10, width of move_count

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high; returns block to IDLE
start  in  1  one-cycle pulse; begins a generation pass (ignored unless IDLE or FIN)
col_done  in  NCOL  per-column done flags
col_empty  in  NCOL  per-column FIFO empty flags
col_data  in  NCOL*MOVE_W  column FIFO q outputs; column i at [i*MOVE_W +: MOVE_W]
col_rden  out  NCOL  per-column FIFO read enable, one-hot or zero
col_reset  out  1  reset to all column units
out_valid  out  1  out_data/out_col valid
out_ready  in  1  consumer accepts when out_valid & out_ready
out_data  out  MOVE_W  move word
out_col  out  3  source column of out_data
move_count  out  CNT_W  moves delivered this pass; saturates at all-ones
busy  out  1  high in CLR/SCAN/RD/LAT/PUSH
done  out  1  high in FIN until next start or reset

Behaviour:
- Reset values: col_rden=0, col_reset=1 (held while reset is high), out_valid=0, out_data=0, out_col=0, move_count=0, busy=0, done=0, rr_ptr=0, state=IDLE.
- Column FIFOs are non-show-ahead: data appears on col_data one cycle after the rden cycle.
- IDLE: col_reset=0. On start -> CLR, move_count<=0, clear-counter<=0.
- CLR: col_reset=1 for exactly CLR_CYC cycles, then -> SCAN. col_done/col_empty are ignored during CLR and on the first SCAN cycle (1-cycle settle).
- SCAN: eligible[i] = ~col_empty[i].
  - If any column is eligible, grant the first one at or after rr_ptr, wrapping 7->0. Latch it as sel -> RD.
  - Else if &col_done and &col_empty -> FIN.
  - Else stay in SCAN.
- RD: col_rden[sel]=1 for exactly one cycle -> LAT.
- LAT: out_data<=col_data[sel], out_col<=sel, out_valid<=1 -> PUSH.
- PUSH: hold out_valid, out_data and out_col stable until out_ready. On the handshake: out_valid<=0, move_count+1 (saturating), rr_ptr<=sel+1 (mod 8), -> SCAN.
- Throughput: one move per 4 cycles when out_ready is held high.
- Fairness: each column supplies at most one move before every other non-empty column is served once.
- FIN: done=1, busy=0. start -> CLR and clears done on the next edge.
- start while busy is ignored.
- reset mid-pass: aborts immediately and drops any pending out_valid. The unread move is lost; the columns are re-cleared by col_reset.
- col_rden is never asserted for a column whose col_empty was high in the SCAN grant cycle.
- col_rden is never asserted while out_valid=1.
- A column that becomes empty after being done is never selected again.
- A column that is done but still non-empty is drained before FIN.

Test Plan:
1. reset, start; columns 0 and 5 each hold 2 moves, all col_done=1, out_ready=1 -> 4 beats with out_col order 0,5,0,5; move_count=4; done rises 1 cycle after the last handshake plus the SCAN check.
2. start; all FIFOs empty and all col_done=1 after CLR -> col_reset high for exactly 2 cycles; FIN reached with move_count=0 and no col_rden pulse.
3. one move in column 3 (data=160'hA5...), out_ready low for 10 cycles -> out_valid, out_data and out_col=3 held stable the whole time; single col_rden[3] pulse; count increments only on the ready cycle.
4. rr_ptr=7 after serving column 6; columns 7 and 1 non-empty -> column 7 granted, then column 1 (wrap-around).
5. assert reset while in PUSH with out_valid=1 -> next cycle out_valid=0, state IDLE, move_count=0, col_reset=1.
6. start pulse issued during SCAN -> no return to CLR; pass completes normally; 1100 moves -> move_count saturates at 1023.
